// File: rtl/enc_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder.
package enc_pkg;

    localparam int W_IN   = 8;
    localparam int W_CODE = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-bit priority encoder with selectable scan direction.
module pri_enc8
    import enc_pkg::*;
(
    input  logic [W_IN-1:0]   vec_i,
    input  logic              lsb_first_i,
    output logic [W_CODE-1:0] idx_o,
    output logic              any_o,
    output logic              one_o
);

    logic [W_CODE-1:0] lo_idx;
    logic [W_CODE-1:0] hi_idx;

    // Later iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = W_IN - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                lo_idx = W_CODE'(i);
            end
        end
        for (int j = 0; j < W_IN; j++) begin
            if (vec_i[j]) begin
                hi_idx = W_CODE'(j);
            end
        end
    end

    assign idx_o = lsb_first_i ? lo_idx : hi_idx;
    assign any_o = |vec_i;
    assign one_o = any_o && ((vec_i & (vec_i - W_IN'(1))) == '0);

endmodule

// File: rtl/enc8_3_seq.sv
// Latches a multi-hot word and streams the index of each set bit.
module enc8_3_seq
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W_IN-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [W_CODE-1:0] out_code,
    output logic              out_last,
    output logic              out_zero,
    input  logic              out_ready
);

    state_t            state_q, state_d;
    logic [W_IN-1:0]   pend_q, pend_d;
    logic [W_CODE-1:0] idx;
    logic              any_set;
    logic              one_set;
    logic              last;

    pri_enc8 u_pri (
        .vec_i       (pend_q),
        .lsb_first_i (LSB_FIRST),
        .idx_o       (idx),
        .any_o       (any_set),
        .one_o       (one_set)
    );

    assign last = one_set || !any_set;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_code  = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pend_d  = in_data;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_code  = idx;
                out_last  = last;
                out_zero  = !any_set;
                if (out_ready) begin
                    pend_d = pend_q & ~(W_IN'(1) << idx);
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_enc8_3_seq.sv
// Directed checks of enc8_3_seq in both scan directions side by side.
module tb_enc8_3_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_out_zero;
    logic [2:0] a_out_code;
    logic       b_in_ready, b_out_valid, b_out_last, b_out_zero;
    logic [2:0] b_out_code;

    int total = 0;
    int bad = 0;

    enc8_3_seq #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_code  (a_out_code),
        .out_last  (a_out_last),
        .out_zero  (a_out_zero),
        .out_ready (out_ready)
    );

    enc8_3_seq #(.LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_code  (b_out_code),
        .out_last  (b_out_last),
        .out_zero  (b_out_zero),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [2:0] ca, input logic [2:0] cb,
                        input logic last, input logic zero);
        chk({tag, " lsb valid"}, 8'(a_out_valid), 8'h1);
        chk({tag, " lsb code"}, 8'(a_out_code), 8'(ca));
        chk({tag, " lsb last"}, 8'(a_out_last), 8'(last));
        chk({tag, " lsb zero"}, 8'(a_out_zero), 8'(zero));
        chk({tag, " lsb rdy"}, 8'(a_in_ready), 8'h0);
        chk({tag, " msb valid"}, 8'(b_out_valid), 8'h1);
        chk({tag, " msb code"}, 8'(b_out_code), 8'(cb));
        chk({tag, " msb last"}, 8'(b_out_last), 8'(last));
        chk({tag, " msb zero"}, 8'(b_out_zero), 8'(zero));
    endtask

    task automatic beat(input string tag, input logic [2:0] ca, input logic [2:0] cb,
                        input logic last, input logic zero);
        look(tag, ca, cb, last, zero);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        chk({tag, " lsb rdy"}, 8'(a_in_ready), 8'h1);
        chk({tag, " lsb valid"}, 8'(a_out_valid), 8'h0);
        chk({tag, " lsb code"}, 8'(a_out_code), 8'h0);
        chk({tag, " lsb last"}, 8'(a_out_last), 8'h0);
        chk({tag, " lsb zero"}, 8'(a_out_zero), 8'h0);
        chk({tag, " msb rdy"}, 8'(b_in_ready), 8'h1);
        chk({tag, " msb valid"}, 8'(b_out_valid), 8'h0);
    endtask

    task automatic send(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle("reset");
        rst = 1'b0;
        @(negedge clk);
        idle("post reset");

        send(8'h05);
        beat("w05 b0", 3'd0, 3'd2, 1'b0, 1'b0);
        beat("w05 b1", 3'd2, 3'd0, 1'b1, 1'b0);
        idle("w05 bubble");

        send(8'h07);
        beat("w07 b0", 3'd0, 3'd2, 1'b0, 1'b0);
        beat("w07 b1", 3'd1, 3'd1, 1'b0, 1'b0);
        beat("w07 b2", 3'd2, 3'd0, 1'b1, 1'b0);
        idle("w07 bubble");

        send(8'h00);
        beat("w00", 3'd0, 3'd0, 1'b1, 1'b1);
        idle("w00 bubble");

        send(8'h06);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_data  = 8'hF9;
            in_valid = 1'b1;
            beat("w06 stall", 3'd1, 3'd2, 1'b0, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        beat("w06 b0", 3'd1, 3'd2, 1'b0, 1'b0);
        beat("w06 b1", 3'd2, 3'd1, 1'b1, 1'b0);
        idle("w06 bubble");

        send(8'hFF);
        beat("wFF b0", 3'd0, 3'd7, 1'b0, 1'b0);
        beat("wFF b1", 3'd1, 3'd6, 1'b0, 1'b0);
        beat("wFF b2", 3'd2, 3'd5, 1'b0, 1'b0);
        look("wFF b3", 3'd3, 3'd4, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle("wFF flushed");

        send(8'h80);
        beat("w80", 3'd7, 3'd7, 1'b1, 1'b0);
        idle("w80 bubble");

        in_data  = 8'h10;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h03;
        beat("b2b w10", 3'd4, 3'd4, 1'b1, 1'b0);
        idle("b2b bubble");
        @(negedge clk);
        in_valid = 1'b0;
        beat("b2b w03 b0", 3'd0, 3'd1, 1'b0, 1'b0);
        beat("b2b w03 b1", 3'd1, 3'd0, 1'b1, 1'b0);
        idle("b2b end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
